// File: rtl/otter_line_mem_if.sv
// Line-request channel between the OTTER data cache and its backing memory.
// The cache is the master; otter_line_mem is the slave.
interface otter_line_mem_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  REQ_VALID;
    logic                  REQ_READY;
    logic                  REQ_WE;
    logic [ADDR_WIDTH-1:0] REQ_ADDR;
    logic [31:0]           WDATA;
    logic                  WVALID;
    logic                  WREADY;
    logic [31:0]           RDATA;
    logic                  RVALID;
    logic                  RLAST;
    logic                  WDONE;
    logic                  ERR;

    modport master (
        output REQ_VALID, REQ_WE, REQ_ADDR, WDATA, WVALID,
        input  REQ_READY, WREADY, RDATA, RVALID, RLAST, WDONE, ERR
    );

    modport slave (
        input  REQ_VALID, REQ_WE, REQ_ADDR, WDATA, WVALID,
        output REQ_READY, WREADY, RDATA, RVALID, RLAST, WDONE, ERR
    );
endinterface

// File: rtl/otter_line_mem.sv
// Main-memory responder for the OTTER data cache: line fill bursts, writeback
// bursts, and programmable access latency over a word-addressed sync RAM.
module otter_line_mem #(
    parameter int ADDR_WIDTH     = 32,
    parameter int WORDS_PER_LINE = 8,
    parameter int DEPTH_WORDS    = 16384,
    parameter int READ_LATENCY   = 4,
    parameter int WRITE_LATENCY  = 2
) (
    input  logic              MEM_CLK,
    input  logic              MEM_RST,
    otter_line_mem_if.slave   bus
);
    localparam int OFF_W   = (WORDS_PER_LINE < 2) ? 1 : $clog2(WORDS_PER_LINE);
    localparam int WADDR_W = $clog2(DEPTH_WORDS);
    localparam int LINE_W  = WADDR_W - OFF_W;
    localparam int LAT_MAX = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
    localparam int CNT_W   = (LAT_MAX < 2) ? 1 : $clog2(LAT_MAX + 1);

    typedef enum logic [2:0] {
        IDLE,
        ERR_RESP,
        RD_WAIT,
        RD_BURST,
        WR_BURST,
        WR_WAIT
    } state_t;

    state_t             state, state_n;
    logic [OFF_W-1:0]   beat, beat_n, rd_beat;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [LINE_W-1:0]  line, line_n;
    logic               mem_we, rd_en;
    logic [31:0]        rdata;
    logic [31:0]        mem [DEPTH_WORDS];

    logic               in_range;
    logic [LINE_W-1:0]  req_line;
    logic               last_beat;
    logic               unused_addr_bits;

    // Only the word address matters for the range check; byte offset is don't-care.
    assign in_range  = {2'b00, bus.REQ_ADDR[ADDR_WIDTH-1:2]} < ADDR_WIDTH'(DEPTH_WORDS);
    assign req_line  = bus.REQ_ADDR[WADDR_W+1:OFF_W+2];
    assign last_beat = (beat == OFF_W'(WORDS_PER_LINE - 1));
    assign unused_addr_bits = ^bus.REQ_ADDR[1:0];

    always_ff @(posedge MEM_CLK) begin
        if (MEM_RST) begin
            state <= IDLE;
            beat  <= '0;
            cnt   <= '0;
            line  <= '0;
        end else begin
            state <= state_n;
            beat  <= beat_n;
            cnt   <= cnt_n;
            line  <= line_n;
        end
    end

    always_comb begin
        state_n = state;
        beat_n  = beat;
        cnt_n   = cnt;
        line_n  = line;
        mem_we  = 1'b0;
        rd_en   = 1'b0;
        rd_beat = beat;
        case (state)
            IDLE: begin
                if (bus.REQ_VALID) begin
                    line_n = req_line;
                    beat_n = '0;
                    if (!in_range) begin
                        state_n = ERR_RESP;
                    end else if (bus.REQ_WE) begin
                        state_n = WR_BURST;
                    end else begin
                        state_n = RD_WAIT;
                        cnt_n   = CNT_W'(READ_LATENCY - 1);
                    end
                end
            end
            ERR_RESP: state_n = IDLE;
            RD_WAIT: begin
                // Word 0 is fetched on the last wait edge so it is on RDATA
                // the first cycle of RD_BURST.
                if (cnt == '0) begin
                    state_n = RD_BURST;
                    beat_n  = '0;
                    rd_en   = 1'b1;
                    rd_beat = '0;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            RD_BURST: begin
                if (last_beat) begin
                    state_n = IDLE;
                end else begin
                    beat_n  = beat + 1'b1;
                    rd_en   = 1'b1;
                    rd_beat = beat + 1'b1;
                end
            end
            WR_BURST: begin
                if (bus.WVALID) begin
                    mem_we = 1'b1;
                    if (last_beat) begin
                        state_n = WR_WAIT;
                        cnt_n   = CNT_W'(WRITE_LATENCY);
                    end else begin
                        beat_n = beat + 1'b1;
                    end
                end
            end
            WR_WAIT: begin
                if (cnt == '0) state_n = IDLE;
                else           cnt_n   = cnt - 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge MEM_CLK) begin
        if (mem_we && !MEM_RST) mem[{line, beat}] <= bus.WDATA;
    end

    always_ff @(posedge MEM_CLK) begin
        if (MEM_RST)    rdata <= '0;
        else if (rd_en) rdata <= mem[{line, rd_beat}];
    end

    assign bus.REQ_READY = (state == IDLE);
    assign bus.WREADY    = (state == WR_BURST);
    assign bus.RVALID    = (state == RD_BURST);
    assign bus.RLAST     = (state == RD_BURST) && last_beat;
    assign bus.RDATA     = rdata;
    assign bus.WDONE     = (state == WR_WAIT) && (cnt == '0);
    assign bus.ERR       = (state == ERR_RESP);
endmodule

// File: tb/tb_otter_line_mem.sv
// Randomized bench for otter_line_mem against a sparse word-array model with
// latencies taken directly from the block's timing rules.
module tb_otter_line_mem;
    localparam int RL = 4, WL = 2, WPL = 8, DEPTH = 16384;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    otter_line_mem_if #(.ADDR_WIDTH(32)) bus();

    otter_line_mem #(
        .ADDR_WIDTH(32), .WORDS_PER_LINE(WPL), .DEPTH_WORDS(DEPTH),
        .READ_LATENCY(RL), .WRITE_LATENCY(WL)
    ) dut (
        .MEM_CLK(clk),
        .MEM_RST(rst),
        .bus(bus.slave)
    );

    int total = 0;
    int bad   = 0;
    logic [31:0] ref_mem [int];

    function automatic logic [31:0] ref_rd(int w);
        return ref_mem.exists(w) ? ref_mem[w] : 32'h0;
    endfunction

    function automatic int line_base(logic [31:0] addr);
        return int'(addr >> 2) & ~(WPL - 1);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_read(input logic [31:0] addr, input string tag);
        int base = line_base(addr);
        total++;
        if (bus.REQ_READY !== 1'b1) begin bad++; $display("FAIL %s req_ready before accept got=%b exp=1", tag, bus.REQ_READY); end
        bus.REQ_VALID = 1'b1; bus.REQ_WE = 1'b0; bus.REQ_ADDR = addr;
        tick();
        bus.REQ_VALID = 1'b0; bus.REQ_ADDR = $urandom; bus.REQ_WE = 1'($urandom);
        for (int j = 0; j < RL; j++) begin
            total++;
            if (bus.RVALID !== 1'b0) begin bad++; $display("FAIL %s early rvalid wait=%0d got=%b exp=0", tag, j, bus.RVALID); end
            tick();
        end
        for (int i = 0; i < WPL; i++) begin
            total++;
            if (bus.RVALID !== 1'b1) begin bad++; $display("FAIL %s rvalid beat=%0d got=%b exp=1", tag, i, bus.RVALID); end
            total++;
            if (bus.RDATA !== ref_rd(base + i)) begin bad++; $display("FAIL %s rdata beat=%0d got=%h exp=%h", tag, i, bus.RDATA, ref_rd(base + i)); end
            total++;
            if (bus.RLAST !== (i == WPL - 1)) begin bad++; $display("FAIL %s rlast beat=%0d got=%b exp=%b", tag, i, bus.RLAST, (i == WPL - 1)); end
            tick();
        end
        total++;
        if (bus.RVALID !== 1'b0 || bus.REQ_READY !== 1'b1) begin
            bad++; $display("FAIL %s after burst rvalid=%b req_ready=%b exp 0/1", tag, bus.RVALID, bus.REQ_READY);
        end
    endtask

    // gap < 0 picks 0..2 idle cycles per beat at random.
    task automatic do_write(input logic [31:0] addr, input logic [31:0] d [WPL], input int gap, input string tag);
        int base = line_base(addr);
        int g;
        total++;
        if (bus.REQ_READY !== 1'b1) begin bad++; $display("FAIL %s req_ready before accept got=%b exp=1", tag, bus.REQ_READY); end
        bus.REQ_VALID = 1'b1; bus.REQ_WE = 1'b1; bus.REQ_ADDR = addr;
        tick();
        bus.REQ_VALID = 1'b0; bus.REQ_ADDR = $urandom;
        for (int i = 0; i < WPL; i++) begin
            g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
            for (int k = 0; k < g; k++) begin
                total++;
                if (bus.WREADY !== 1'b1 || bus.WDONE !== 1'b0) begin
                    bad++; $display("FAIL %s gap beat=%0d wready=%b wdone=%b exp 1/0", tag, i, bus.WREADY, bus.WDONE);
                end
                tick();
            end
            bus.WVALID = 1'b1; bus.WDATA = d[i];
            total++;
            if (bus.WREADY !== 1'b1) begin bad++; $display("FAIL %s wready beat=%0d got=%b exp=1", tag, i, bus.WREADY); end
            tick();
            bus.WVALID = 1'b0; bus.WDATA = $urandom;
            ref_mem[base + i] = d[i];
        end
        for (int j = 0; j <= WL; j++) begin
            total++;
            if (bus.WDONE !== (j == WL)) begin bad++; $display("FAIL %s wdone after_last+%0d got=%b exp=%b", tag, j, bus.WDONE, (j == WL)); end
            total++;
            if (bus.WREADY !== 1'b0) begin bad++; $display("FAIL %s wready after_last+%0d got=%b exp=0", tag, j, bus.WREADY); end
            if (j < WL) tick();
        end
        tick();
        total++;
        if (bus.WDONE !== 1'b0 || bus.REQ_READY !== 1'b1) begin
            bad++; $display("FAIL %s after wdone wdone=%b req_ready=%b exp 0/1", tag, bus.WDONE, bus.REQ_READY);
        end
    endtask

    task automatic do_err(input logic [31:0] addr, input string tag);
        total++;
        if (bus.REQ_READY !== 1'b1) begin bad++; $display("FAIL %s req_ready before accept got=%b exp=1", tag, bus.REQ_READY); end
        bus.REQ_VALID = 1'b1; bus.REQ_WE = 1'($urandom); bus.REQ_ADDR = addr;
        tick();
        bus.REQ_VALID = 1'b0;
        total++;
        if (bus.ERR !== 1'b1 || bus.RVALID !== 1'b0 || bus.REQ_READY !== 1'b0 || bus.WREADY !== 1'b0) begin
            bad++; $display("FAIL %s err cycle err=%b rvalid=%b req_ready=%b wready=%b exp 1/0/0/0", tag, bus.ERR, bus.RVALID, bus.REQ_READY, bus.WREADY);
        end
        tick();
        total++;
        if (bus.ERR !== 1'b0 || bus.RVALID !== 1'b0 || bus.REQ_READY !== 1'b1 || bus.WDONE !== 1'b0) begin
            bad++; $display("FAIL %s after err err=%b rvalid=%b req_ready=%b wdone=%b exp 0/0/1/0", tag, bus.ERR, bus.RVALID, bus.REQ_READY, bus.WDONE);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        total++;
        if (bus.REQ_READY !== 1'b1 || bus.WREADY !== 1'b0 || bus.RVALID !== 1'b0 || bus.RLAST !== 1'b0 ||
            bus.WDONE !== 1'b0 || bus.ERR !== 1'b0) begin
            bad++; $display("FAIL reset flags ready=%b wready=%b rvalid=%b rlast=%b wdone=%b err=%b exp 1/0/0/0/0/0",
                            bus.REQ_READY, bus.WREADY, bus.RVALID, bus.RLAST, bus.WDONE, bus.ERR);
        end
        total++;
        if (bus.RDATA !== 32'h0) begin bad++; $display("FAIL reset rdata got=%h exp=0", bus.RDATA); end
        rst = 1'b0;
        tick();
        total++;
        if (bus.REQ_READY !== 1'b1) begin bad++; $display("FAIL reset idle ready got=%b exp=1", bus.REQ_READY); end
    endtask

    task automatic test_write_read();
        logic [31:0] d [WPL];
        for (int i = 0; i < WPL; i++) d[i] = 32'hA0 + i;
        do_write(32'h1240, d, 0, "wr_1240");
        do_read(32'h1240, "rd_1240");
    endtask

    task automatic test_unaligned();
        do_read(32'h125C, "rd_125c");
    endtask

    task automatic test_gaps();
        logic [31:0] d [WPL];
        for (int i = 0; i < WPL; i++) d[i] = 32'hDEADBEEF + i;
        do_write(32'h2000, d, 2, "wr_gap");
        do_read(32'h2000, "rd_gap");
    endtask

    task automatic test_err();
        do_err(32'h0001_0000, "err_10000");
        do_err(32'hFFFF_FFFC, "err_top");
        do_read(32'h0000_FFE0, "rd_last_line");
    endtask

    task automatic test_reset_mid_read();
        bus.REQ_VALID = 1'b1; bus.REQ_WE = 1'b0; bus.REQ_ADDR = 32'h1240;
        tick();
        bus.REQ_VALID = 1'b0;
        repeat (RL + 3) tick();
        total++;
        if (bus.RDATA !== 32'hA3 || bus.RVALID !== 1'b1) begin
            bad++; $display("FAIL mid_rd beat3 rdata=%h rvalid=%b exp a3/1", bus.RDATA, bus.RVALID);
        end
        rst = 1'b1;
        tick();
        total++;
        if (bus.RVALID !== 1'b0 || bus.REQ_READY !== 1'b1 || bus.RLAST !== 1'b0 || bus.RDATA !== 32'h0) begin
            bad++; $display("FAIL mid_rd abort rvalid=%b ready=%b rlast=%b rdata=%h exp 0/1/0/0", bus.RVALID, bus.REQ_READY, bus.RLAST, bus.RDATA);
        end
        rst = 1'b0;
        tick();
        do_read(32'h1240, "rd_after_rst");
    endtask

    task automatic test_reset_mid_write();
        int base = line_base(32'h3000);
        bus.REQ_VALID = 1'b1; bus.REQ_WE = 1'b1; bus.REQ_ADDR = 32'h3000;
        tick();
        bus.REQ_VALID = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.WVALID = 1'b1; bus.WDATA = $urandom;
            ref_mem[base + i] = bus.WDATA;
            tick();
        end
        bus.WVALID = 1'b0;
        rst = 1'b1;
        tick();
        total++;
        if (bus.WREADY !== 1'b0 || bus.WDONE !== 1'b0 || bus.REQ_READY !== 1'b1) begin
            bad++; $display("FAIL mid_wr abort wready=%b wdone=%b ready=%b exp 0/0/1", bus.WREADY, bus.WDONE, bus.REQ_READY);
        end
        rst = 1'b0;
        for (int k = 0; k < WL + 2; k++) begin
            tick();
            total++;
            if (bus.WDONE !== 1'b0) begin bad++; $display("FAIL mid_wr stray wdone cyc=%0d got=%b exp=0", k, bus.WDONE); end
        end
        do_read(32'h3000, "rd_partial");
    endtask

    task automatic test_random();
        logic [31:0] d [WPL];
        logic [31:0] addr;
        int r;
        for (int it = 0; it < 12; it++) begin
            r = int'($urandom_range(0, 9));
            if (r < 2) begin
                addr = $urandom | 32'h0001_0000;
                do_err(addr, "rnd_err");
            end else begin
                // Half the picks reuse already-written lines so readback has content.
                addr = (r < 6) ? 32'(($urandom_range(0, 3) * 32) + 32'h4000 + $urandom_range(0, 31))
                               : 32'($urandom_range(0, 32'hFFFF));
                if (r < 6 && it % 2 == 0 || r >= 8) begin
                    for (int i = 0; i < WPL; i++) d[i] = $urandom;
                    do_write(addr, d, -1, "rnd_wr");
                end else begin
                    do_read(addr, "rnd_rd");
                end
            end
            repeat (int'($urandom_range(0, 2))) tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d [WPL];
        for (int i = 0; i < WPL; i++) d[i] = $urandom;
        do_write(32'h8100, d, 0, "b2b_wr");
        do_read(32'h8104, "b2b_rd");
        do_err(32'h0002_0040, "b2b_err");
        do_read(32'h8100, "b2b_rd2");
    endtask

    initial begin
        bus.REQ_VALID = 1'b0;
        bus.REQ_WE    = 1'b0;
        bus.REQ_ADDR  = '0;
        bus.WDATA     = '0;
        bus.WVALID    = 1'b0;
        #1;
        test_reset();
        test_write_read();
        test_unaligned();
        test_gaps();
        test_err();
        test_reset_mid_read();
        test_reset_mid_write();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/otter_line_mem.md
Name: otter_line_mem

Overview:
- Main-memory responder sitting behind the OTTER data cache.
- Serves the cache's line fills (read bursts) and dirty-line writebacks (write bursts) over a valid/ready request channel with fixed beat order.
- Has programmable access latency, so the cache miss/writeback paths see realistic stall lengths.
- Backed by a word-addressed synchronous RAM array.

Parameters:
- ADDR_WIDTH, 32, width of the byte address on REQ_ADDR.
- WORDS_PER_LINE, 8, words per cache line (32-byte line); must be a power of 2.
- DEPTH_WORDS, 16384, array size in 32-bit words (64 KiB, byte addresses 0x0000-0xFFFF).
- READ_LATENCY, 4, number of cycles from request accept to the first read beat; must be ≥1.
- WRITE_LATENCY, 2, number of cycles from last write beat to WDONE; may be 0.

Ports:
- MEM_CLK  in  1  clock; all state changes on the rising edge.
- MEM_RST  in  1  synchronous, active-high reset.
- REQ_VALID  in  1  cache presents a line request.
- REQ_READY  out  1  responder can accept a request; high only in IDLE.
- REQ_WE  in  1  1 = writeback (write burst), 0 = fill (read burst).
- REQ_ADDR  in  ADDR_WIDTH  byte address; low log2(WORDS_PER_LINE)+2 bits ignored.
- WDATA  in  32  write beat data.
- WVALID  in  1  write beat valid.
- WREADY  out  1  responder accepts write beats; high only in WR_BURST.
- RDATA  out  32  read beat data, registered.
- RVALID  out  1  read beat valid.
- RLAST  out  1  marks the final read beat.
- WDONE  out  1  one-cycle pulse: writeback committed.
- ERR  out  1  one-cycle pulse: request address out of range.

Behaviour:
- Reset (MEM_RST high at an edge): state returns to IDLE.
  - After reset: REQ_READY=1, WREADY=0, RVALID=0, RLAST=0, RDATA=0, WDONE=0, ERR=0; beat and latency counters are cleared.
  - Array contents are not cleared by reset; they are zero at time 0 in simulation.
- Accept: a request is accepted at an edge where REQ_VALID & REQ_READY.
  - REQ_WE and line index (REQ_ADDR[ADDR_WIDTH-1:log2(WORDS_PER_LINE)+2]) are latched at that edge.
  - Word address = {line index, beat count}.
- Range check at accept: if REQ_ADDR[ADDR_WIDTH-1:2] ≥ DEPTH_WORDS → ERR_RESP.
- States:
  - IDLE: REQ_READY=1.
    - Accepted, in range, REQ_WE=1 → WR_BURST with beat=0.
    - Accepted, in range, REQ_WE=0 → RD_WAIT with cnt=READ_LATENCY-1.
  - ERR_RESP: ERR=1 for exactly this one cycle; no array access, no RVALID/WDONE. Next state IDLE.
  - RD_WAIT: decrement cnt; at 0 → RD_BURST with beat=0. The first RVALID is high in the cycle following edge N+READ_LATENCY, where N is the accept edge.
  - RD_BURST: WORDS_PER_LINE consecutive beats, ascending word 0..WORDS_PER_LINE-1, one per cycle.
    - No backpressure: the cache must sink every beat.
    - RLAST=1 only with beat WORDS_PER_LINE-1; the following cycle RVALID=0 and state is IDLE.
  - WR_BURST: WREADY=1. Each edge with WVALID writes WDATA to word beat, then beat++.
    - Gaps in WVALID are allowed; WREADY stays high through them.
    - After the final beat → WR_WAIT with cnt=WRITE_LATENCY.
  - WR_WAIT: decrement cnt. WDONE is high in the cycle following edge M+WRITE_LATENCY, where M is the last-beat edge; WRITE_LATENCY=0 gives WDONE in the cycle right after M. Then IDLE.
- REQ_* inputs outside IDLE are ignored. The cache must hold REQ_VALID until REQ_READY.
- RDATA holds its last value when RVALID=0.
- Reset mid-operation: abort to IDLE next cycle; all outputs take their reset values.
  - Write beats already taken remain in the array; no WDONE is issued for the aborted burst.
- Read immediately after write to the same line returns the new data (the write commits before WDONE).

Test Plan:
- Reset: MEM_RST high 3 cycles → REQ_READY=1; WREADY, RVALID, RLAST, WDONE, ERR all 0; RDATA=0.
- Write REQ_ADDR=0x1240 with 8 back-to-back beats 0xA0..0xA7 → WREADY high for 8 cycles; WDONE single pulse in the cycle after edge last+2. Then read 0x1240 → first RVALID in the cycle after edge accept+4; 8 consecutive beats 0xA0..0xA7; RLAST only on 0xA7.
- Read REQ_ADDR=0x125C (unaligned, same line) → identical burst 0xA0..0xA7, starting at word 0.
- Write 0x2000 with WVALID gaps (2 idle cycles between each beat), data 0xDEADBEEF+i → WREADY stays 1 through the gaps; readback of 0x2000 matches all 8 words.
- Read REQ_ADDR=0x0001_0000 (out of range) → ERR high exactly one cycle after accept; no RVALID; REQ_READY=1 the following cycle.
- Reset asserted after read beat 3 of 0x1240 → RVALID=0 and REQ_READY=1 the next cycle. A fresh read of 0x1240 returns 0xA0..0xA7 with normal latency.
